// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arbiter_rr_pkg: shared bus-arbitration constants and FSM state encodings.
package bus_arbiter_rr_pkg;
    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W = 2;
    localparam int BUS_TIMEOUT_DEF = 255;
    typedef enum logic {
        BUS_ARB_OWN = 1'b0,
        BUS_ARB_RECOVER = 1'b1
    } bus_arb_state_e;
endpackage

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: master request/grant lines plus bus-status signals of the arbiter.
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W = 2
);
    logic [NUM_MASTERS-1:0] m_req_;
    logic [NUM_MASTERS-1:0] m_grnt_;
    logic s_as_;
    logic m_rdy_;
    logic [OWNER_W-1:0] owner;
    logic bus_busy;
    logic timeout_;
    logic [OWNER_W-1:0] err_master;
    modport master (
        output m_req_, s_as_, m_rdy_,
        input m_grnt_, owner, bus_busy, timeout_, err_master
    );
    modport slave (
        input m_req_, s_as_, m_rdy_,
        output m_grnt_, owner, bus_busy, timeout_, err_master
    );
endinterface

// File: rtl/bus_arbiter_rr_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after start (wrapping).
module rr_pick
    import bus_arbiter_rr_pkg::*;
#(
    parameter int N = BUS_MASTER_CH,
    parameter int W = BUS_OWNER_W
) (
    input logic [N-1:0] req,
    input logic [W-1:0] start,
    output logic found,
    output logic [W-1:0] idx
);
    logic [2*N-1:0] dbl;
    logic [W:0] sum;
    logic [W-1:0] off;
    // Rotating a doubled vector puts master start at bit 0, so the lowest set bit is the winner.
    always_comb begin
        dbl = {req, req} >> start;
        off = '0;
        for (int k = N - 1; k >= 0; k--) off = dbl[k] ? W'(k) : off;
        sum = {1'b0, start} + {1'b0, off};
        idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    end
    assign found = |req;
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter with stall watchdog and per-master abort masking.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_MASTERS = BUS_MASTER_CH,
    parameter int OWNER_W = BUS_OWNER_W,
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEF,
    parameter int TO_W = 8
) (
    input logic clk,
    input logic reset,
    bus_arbiter_rr_if.slave bus
);
    bus_arb_state_e state, state_n;
    logic [OWNER_W-1:0] owner_q, owner_n, start, pick_idx;
    logic [NUM_MASTERS-1:0] mask, mask_n, req, grnt_n;
    logic [TO_W-1:0] wdog, wdog_n;
    logic pick_found, own_req, stall, fire, change;
    assign req = ~bus.m_req_ & ~mask;
    assign own_req = ~bus.m_req_[owner_q];
    assign stall = ~bus.s_as_ & bus.m_rdy_;
    assign start = (owner_q == OWNER_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
    assign bus.owner = owner_q;
    rr_pick #(.N(NUM_MASTERS), .W(OWNER_W)) u_pick (
        .req(req),
        .start(start),
        .found(pick_found),
        .idx(pick_idx)
    );
    always_comb begin
        state_n = state;
        owner_n = owner_q;
        fire = 1'b0;
        change = 1'b0;
        if (state == BUS_ARB_RECOVER) begin
            state_n = pick_found ? BUS_ARB_OWN : BUS_ARB_RECOVER;
            owner_n = pick_found ? pick_idx : owner_q;
        end else if (!own_req) begin
            change = pick_found;
            owner_n = pick_found ? pick_idx : owner_q;
        end else if (stall && wdog == TO_W'(TIMEOUT_CYCLES - 1)) begin
            fire = 1'b1;
            state_n = BUS_ARB_RECOVER;
        end
        // A master dropping its request unmasks it; the aborted owner is still requesting so its new bit sticks.
        mask_n = (mask & ~bus.m_req_) | (fire ? NUM_MASTERS'(1) << owner_q : '0);
        wdog_n = (state == BUS_ARB_OWN && stall && !fire && !change) ? wdog + 1'b1 : '0;
        grnt_n = (state_n == BUS_ARB_OWN) ? ~(NUM_MASTERS'(1) << owner_n) : '1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BUS_ARB_OWN;
            owner_q <= '0;
            mask <= '0;
            wdog <= '0;
            bus.m_grnt_ <= ~NUM_MASTERS'(1);
            bus.bus_busy <= 1'b1;
            bus.timeout_ <= 1'b1;
            bus.err_master <= '0;
        end else begin
            state <= state_n;
            owner_q <= owner_n;
            mask <= mask_n;
            wdog <= wdog_n;
            bus.m_grnt_ <= grnt_n;
            bus.bus_busy <= (state_n == BUS_ARB_OWN);
            bus.timeout_ <= ~fire;
            bus.err_master <= fire ? owner_q : bus.err_master;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed stimulus with a per-cycle behavioural model for a 4-master arbiter, plus an 8-master wrap run.
module tb_bus_arbiter_rr;
    localparam int N = 4;
    localparam int T = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    bus_arbiter_rr_if #(.NUM_MASTERS(N), .OWNER_W(2)) bus ();
    bus_arbiter_rr_if #(.NUM_MASTERS(8), .OWNER_W(3)) bus8 ();
    bus_arbiter_rr #(.NUM_MASTERS(N), .OWNER_W(2), .TIMEOUT_CYCLES(T), .TO_W(8)) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );
    bus_arbiter_rr #(.NUM_MASTERS(8), .OWNER_W(3), .TIMEOUT_CYCLES(255), .TO_W(8)) dut8 (
        .clk(clk),
        .reset(rst_n),
        .bus(bus8)
    );
    always #5 clk = ~clk;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: owner index, recovering flag, consecutive-stall run length, abort mask.
    int e_owner = 0;
    int e_err = 0;
    int e_stall = 0;
    bit e_rec = 1'b0;
    bit e_to = 1'b1;
    bit [N-1:0] e_mask = '0;
    function automatic int find(int from, logic [N-1:0] rq, bit [N-1:0] mk);
        for (int k = 0; k < N; k++) begin
            if (!rq[(from + k) % N] && !mk[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction
    function automatic logic [N-1:0] exp_grnt(bit rec, int own);
        logic [N-1:0] g;
        g = '1;
        if (!rec) g[own] = 1'b0;
        return g;
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_owner <= 0;
            e_err <= 0;
            e_stall <= 0;
            e_rec <= 1'b0;
            e_to <= 1'b1;
            e_mask <= '0;
        end else begin
            automatic int nxt = find(e_owner + 1, bus.m_req_, e_mask);
            automatic int run = (!bus.s_as_ && bus.m_rdy_) ? e_stall + 1 : 0;
            automatic bit [N-1:0] kept = e_mask & ~bus.m_req_;
            e_to <= 1'b1;
            e_mask <= kept;
            if (e_rec) begin
                e_stall <= 0;
                if (nxt >= 0) begin
                    e_rec <= 1'b0;
                    e_owner <= nxt;
                end
            end else if (bus.m_req_[e_owner] && nxt >= 0) begin
                e_owner <= nxt;
                e_stall <= 0;
            end else if (!bus.m_req_[e_owner] && run == T) begin
                e_to <= 1'b0;
                e_err <= e_owner;
                e_rec <= 1'b1;
                e_stall <= 0;
                e_mask <= kept | (bit'(1) << e_owner);
            end else begin
                e_stall <= run;
            end
        end
    end
    always @(negedge clk) begin
        check("model m_grnt_", bus.m_grnt_, exp_grnt(e_rec, e_owner));
        check("model owner", bus.owner, e_owner);
        check("model bus_busy", bus.bus_busy, !e_rec);
        check("model timeout_", bus.timeout_, e_to);
        check("model err_master", bus.err_master, e_err);
    end
    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic check_reset_vals(string tag);
        check({tag, " m_grnt_"}, bus.m_grnt_, 4'b1110);
        check({tag, " owner"}, bus.owner, 0);
        check({tag, " bus_busy"}, bus.bus_busy, 1);
        check({tag, " timeout_"}, bus.timeout_, 1);
        check({tag, " err_master"}, bus.err_master, 0);
    endtask
    initial begin
        logic [7:0] g8;
        bus.m_req_ = 4'b1111;
        bus.s_as_ = 1'b1;
        bus.m_rdy_ = 1'b1;
        bus8.m_req_ = 8'hFF;
        bus8.s_as_ = 1'b1;
        bus8.m_rdy_ = 1'b1;
        tick(2);
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        check("idle park", bus.m_grnt_, 4'b1110);
        // Everyone requesting; each owner in turn releases and the next index wins.
        bus.m_req_ = 4'b0000;
        tick();
        for (int k = 0; k < N; k++) begin
            bus.m_req_ = 4'(1 << k);
            tick();
            check("wrap owner", bus.owner, (k + 1) % N);
        end
        bus.m_req_ = 4'b1101;
        tick();
        check("to owner1", bus.owner, 1);
        bus.m_req_ = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold owner1", bus.m_grnt_, 4'b1101);
        end
        bus.m_req_ = 4'b0011;
        tick();
        check("rr picks 2", bus.m_grnt_, 4'b1011);
        // Owner 2 stalls for T cycles and is aborted.
        bus.s_as_ = 1'b0;
        tick(3);
        check("no early abort", bus.timeout_, 1);
        tick();
        check("abort timeout_", bus.timeout_, 0);
        check("abort grants off", bus.m_grnt_, 4'b1111);
        check("abort err_master", bus.err_master, 2);
        bus.s_as_ = 1'b1;
        tick();
        check("after abort owner", bus.m_grnt_, 4'b0111);
        check("pulse one cycle", bus.timeout_, 1);
        bus.m_req_ = 4'b1011;
        tick();
        check("masked not granted", bus.owner, 3);
        bus.m_req_ = 4'b1111;
        tick();
        bus.m_req_ = 4'b1011;
        tick();
        check("unmasked granted", bus.owner, 2);
        // Ready arriving on stall cycle T-1 restarts the watchdog.
        bus.s_as_ = 1'b0;
        tick(2);
        bus.m_rdy_ = 1'b0;
        tick();
        bus.m_rdy_ = 1'b1;
        tick(3);
        check("rdy restarts wdog", bus.timeout_, 1);
        tick();
        check("late abort", bus.timeout_, 0);
        bus.s_as_ = 1'b1;
        tick();
        check("recover idle grants", bus.m_grnt_, 4'b1111);
        check("recover idle busy", bus.bus_busy, 0);
        bus.m_req_ = 4'b1111;
        tick();
        bus.m_req_ = 4'b1011;
        tick();
        check("leave recover", bus.m_grnt_, 4'b1011);
        // Release on the abort cycle wins over the watchdog.
        bus.m_req_ = 4'b0011;
        bus.s_as_ = 1'b0;
        tick(3);
        bus.m_req_ = 4'b0111;
        tick();
        check("release beats abort", bus.timeout_, 1);
        check("release new owner", bus.owner, 3);
        tick(4);
        check("abort owner3", bus.err_master, 3);
        bus.m_req_ = 4'b0011;
        tick();
        check("owner2 while 3 masked", bus.owner, 2);
        tick(3);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async reset");
        tick();
        rst_n = 1'b1;
        bus.s_as_ = 1'b1;
        bus.m_req_ = 4'b0111;
        tick();
        check("mask cleared by reset", bus.owner, 3);
        bus.m_req_ = 4'b1111;
        tick();
        bus8.m_req_ = 8'h00;
        tick();
        for (int k = 0; k < 8; k++) begin
            bus8.m_req_ = 8'(1 << k);
            tick();
            g8 = ~(8'd1 << ((k + 1) % 8));
            check("n8 wrap owner", bus8.owner, (k + 1) % 8);
            check("n8 wrap grant", bus8.m_grnt_, g8);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
